// File: rtl/sega_pkg.sv
// Shared definitions for the SMS cartridge mapper: FSM encoding, control
// window location and the power-on bank assignment of the three ROM slots.
package sega_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } map_state_t;

    // addr[15:2] of the FFFC-FFFF control window
    localparam logic [13:0] WIN_HI_DEF = 14'h3FFF;

    localparam int SLOT0_RST = 0;
    localparam int SLOT1_RST = 1;
    localparam int SLOT2_RST = 2;

    // Reset bank for slot n (0..2)
    function automatic int slot_rst(input int n);
        case (n)
            0:       return SLOT0_RST;
            1:       return SLOT1_RST;
            default: return SLOT2_RST;
        endcase
    endfunction

endpackage

// File: rtl/mapper_regfile.sv
// Shadow/active register pair for the mapper. CPU writes land in the shadow
// set immediately; the active set, which drives translation, only picks up
// the shadow contents (including a write on the same edge) on commit.
module mapper_regfile
    import sega_pkg::*;
#(
    parameter int BANK_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [1:0]           idx,
    input  logic [7:0]           data_in,
    input  logic                 commit,
    output logic                 ram_en,
    output logic                 ram_bank,
    output logic [BANK_BITS-1:0] slot0,
    output logic [BANK_BITS-1:0] slot1,
    output logic [BANK_BITS-1:0] slot2
);

    // ctrl is kept as {ram_en, ram_bank}; the other data bits carry nothing
    logic [1:0]                ctrl_shadow, ctrl_shadow_next, ctrl_active;
    logic [2:0][BANK_BITS-1:0] slot_shadow, slot_shadow_next, slot_active;
    logic                      unused_data;

    assign unused_data = ^data_in;

    // Shadow contents as they will be after this edge
    always_comb begin
        ctrl_shadow_next = ctrl_shadow;
        slot_shadow_next = slot_shadow;
        if (wr_en) begin
            case (idx)
                2'd0:    ctrl_shadow_next    = data_in[3:2];
                2'd1:    slot_shadow_next[0] = BANK_BITS'(data_in);
                2'd2:    slot_shadow_next[1] = BANK_BITS'(data_in);
                default: slot_shadow_next[2] = BANK_BITS'(data_in);
            endcase
        end
    end

    // Shadow tracks writes every edge; active follows shadow only on commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_shadow <= '0;
            ctrl_active <= '0;
            for (int i = 0; i < 3; i++) begin
                slot_shadow[i] <= BANK_BITS'(slot_rst(i));
                slot_active[i] <= BANK_BITS'(slot_rst(i));
            end
        end else begin
            ctrl_shadow <= ctrl_shadow_next;
            slot_shadow <= slot_shadow_next;
            if (commit) begin
                ctrl_active <= ctrl_shadow_next;
                slot_active <= slot_shadow_next;
            end
        end
    end

    assign ram_en   = ctrl_active[1];
    assign ram_bank = ctrl_active[0];
    assign slot0    = slot_active[0];
    assign slot1    = slot_active[1];
    assign slot2    = slot_active[2];

endmodule

// File: rtl/sms_mapper.sv
// SMS cartridge mapper: decodes writes to the FFFC-FFFF control window,
// raises paging_RQ until the pipeline reports a flush, and translates CPU
// addresses into ROM / cartridge RAM / system RAM selects.
//
//   state | meaning
//   IDLE  | no paging change outstanding
//   PEND  | window written, waiting for flush0 to commit the new mapping
module sms_mapper
    import sega_pkg::*;
#(
    parameter int          BANK_BITS  = 5,
    parameter int          TMO_CYCLES = 15,
    parameter logic [13:0] WIN_HI     = WIN_HI_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  MREQ,
    input  logic                  Rd_Wr,
    input  logic [15:0]           addr,
    input  logic [7:0]            data_in,
    input  logic                  flush0,
    output logic                  paging_RQ,
    output logic [BANK_BITS+13:0] rom_addr,
    output logic                  cram_sel,
    output logic [14:0]           cram_addr,
    output logic                  sram_sel,
    output logic                  timeout_err
);

    localparam int CNT_W = ($clog2(TMO_CYCLES + 1) > 4) ? $clog2(TMO_CYCLES + 1) : 4;
    localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TMO_CYCLES);

    map_state_t           state, state_next;
    logic                 wr_hit, commit;
    logic [CNT_W-1:0]     wait_cnt, wait_inc;
    logic                 ram_en, ram_bank;
    logic [BANK_BITS-1:0] slot0, slot1, slot2;

    assign wr_hit = MREQ && !Rd_Wr && (addr[15:2] == WIN_HI);
    assign commit = flush0 && ((state == ST_PEND) || wr_hit);

    mapper_regfile #(
        .BANK_BITS (BANK_BITS)
    ) u_regfile (
        .clk      (CLK),
        .rst      (RST),
        .wr_en    (wr_hit),
        .idx      (addr[1:0]),
        .data_in  (data_in),
        .commit   (commit),
        .ram_en   (ram_en),
        .ram_bank (ram_bank),
        .slot0    (slot0),
        .slot1    (slot1),
        .slot2    (slot2)
    );

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and paging request; flush0 takes priority over a new write
    always_comb begin
        state_next = state;
        paging_RQ  = wr_hit;
        case (state)
            ST_IDLE: begin
                if (wr_hit && !flush0) begin
                    state_next = ST_PEND;
                end
            end
            ST_PEND: begin
                paging_RQ = 1'b1;
                if (flush0) begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    assign wait_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;

    // Count PEND cycles; timeout_err is sticky once the budget is used up
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else if (state == ST_PEND) begin
            wait_cnt <= wait_inc;
            if (wait_inc == CNT_TMO) begin
                timeout_err <= 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    // Address translation from the committed mapping; the first 1 KB is fixed to bank 0
    always_comb begin
        rom_addr  = {{BANK_BITS{1'b0}}, addr[13:0]};
        cram_addr = {ram_bank, addr[13:0]};
        cram_sel  = 1'b0;
        sram_sel  = 1'b0;
        case (addr[15:14])
            2'b00: begin
                if (addr[13:10] != 4'd0) begin
                    rom_addr = {slot0, addr[13:0]};
                end
            end
            2'b01: rom_addr = {slot1, addr[13:0]};
            2'b10: begin
                rom_addr = {slot2, addr[13:0]};
                cram_sel = ram_en;
            end
            default: sram_sel = 1'b1;
        endcase
    end

endmodule
